// File: rtl/rgb_link_monitor_if.sv
// Link-monitor bus: per-link samples in, lock/error status out.
// STICKY_ERR_EN adds O_err_sticky.
interface rgb_link_monitor_if #(
  parameter int LINKS     = 2,
  parameter int DATA_W    = 24,
  parameter int ERR_CNT_W = 16
);
  logic [LINKS-1:0]                I_valid;
  logic [LINKS-1:0][DATA_W-1:0]    I_data;
  logic                            I_clr_cnt;
  logic [LINKS-1:0]                O_lock;
  logic [LINKS-1:0]                O_err;
  logic [LINKS-1:0][ERR_CNT_W-1:0] O_err_cnt;
  logic                            O_all_ok;
`ifdef STICKY_ERR_EN
  logic [LINKS-1:0]                O_err_sticky;

  modport master (output I_valid, I_data, I_clr_cnt,
                  input  O_lock, O_err, O_err_cnt, O_all_ok, O_err_sticky);
  modport slave  (input  I_valid, I_data, I_clr_cnt,
                  output O_lock, O_err, O_err_cnt, O_all_ok, O_err_sticky);
`else
  modport master (output I_valid, I_data, I_clr_cnt,
                  input  O_lock, O_err, O_err_cnt, O_all_ok);
  modport slave  (input  I_valid, I_data, I_clr_cnt,
                  output O_lock, O_err, O_err_cnt, O_all_ok);
`endif
endinterface

// File: rtl/rgb_link_monitor.sv
// N-link incrementing-pattern checker: per-link lock FSM, saturating error count,
// aggregated LED flag. Optional macro STICKY_ERR_EN adds per-link sticky error flags.
module rgb_link_lane #(
  parameter int DATA_W     = 24,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_ERR = 4,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid,
  input  logic                 clr,
  input  logic [DATA_W-1:0]    data,
  output logic                 lock_q,
  output logic                 err_q,
  output logic [ERR_CNT_W-1:0] cnt_q,
  output logic                 lock_d,
  output logic                 err_d
`ifdef STICKY_ERR_EN
  ,
  output logic                 sticky_q,
  output logic                 sticky_d
`endif
);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(UNLOCK_ERR + 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t                state_q, state_d;
  logic [DATA_W-1:0]     prev_q, prev_d;
  logic                  prev_vld_q, prev_vld_d;
  logic [GW-1:0]         good_q, good_d;
  logic [BW-1:0]         bad_q, bad_d;
  logic [ERR_CNT_W-1:0]  cnt_d, cnt_base;
  logic                  match;

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    good_d     = good_q;
    bad_d      = bad_q;
    err_d      = 1'b0;
    // a clear in the same cycle as an error leaves exactly that one error counted
    cnt_base   = clr ? '0 : cnt_q;
    cnt_d      = cnt_base;
    match      = prev_vld_q && (data == prev_q + DATA_W'(1));
    if (valid) begin
      prev_d     = data;
      prev_vld_d = 1'b1;
      case (state_q)
        SEARCH:
          if (!match) good_d = '0;
          else if (good_q == GW'(LOCK_CNT - 1)) begin
            state_d = LOCKED;
            good_d  = '0;
            bad_d   = '0;
          end else good_d = good_q + GW'(1);
        LOCKED:
          if (match) bad_d = '0;
          else begin
            err_d = 1'b1;
            if (!(&cnt_base)) cnt_d = cnt_base + ERR_CNT_W'(1);
            if (bad_q == BW'(UNLOCK_ERR - 1)) begin
              state_d = SEARCH;
              good_d  = '0;
              bad_d   = '0;
            end else bad_d = bad_q + BW'(1);
          end
      endcase
    end
    lock_d = (state_d == LOCKED);
`ifdef STICKY_ERR_EN
    sticky_d = err_d | (sticky_q & ~clr);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= SEARCH;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      good_q     <= '0;
      bad_q      <= '0;
      cnt_q      <= '0;
      lock_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef STICKY_ERR_EN
      sticky_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      cnt_q      <= cnt_d;
      lock_q     <= lock_d;
      err_q      <= err_d;
`ifdef STICKY_ERR_EN
      sticky_q   <= sticky_d;
`endif
    end
  end
endmodule

module rgb_link_monitor #(
  parameter int LINKS      = 2,
  parameter int DATA_W     = 24,
  parameter int LOCK_CNT   = 16,
  parameter int UNLOCK_ERR = 4,
  parameter int ERR_CNT_W  = 16
) (
  input  logic               I_clk,
  input  logic               I_rst,
  rgb_link_monitor_if.slave  bus
);
  logic [LINKS-1:0]                valid, lock_q, err_q, lock_d, err_d;
  logic [LINKS-1:0][DATA_W-1:0]    data;
  logic [LINKS-1:0][ERR_CNT_W-1:0] cnt_q;
  logic                            all_ok_q, all_ok_d;
`ifdef STICKY_ERR_EN
  logic [LINKS-1:0]                sticky_q, sticky_d;
`endif

  assign valid = bus.I_valid;
  assign data  = bus.I_data;

  rgb_link_lane #(
    .DATA_W(DATA_W), .LOCK_CNT(LOCK_CNT), .UNLOCK_ERR(UNLOCK_ERR), .ERR_CNT_W(ERR_CNT_W)
  ) u_lane [LINKS-1:0] (
    .clk(I_clk), .rst(I_rst), .valid(valid), .clr(bus.I_clr_cnt), .data(data),
    .lock_q(lock_q), .err_q(err_q), .cnt_q(cnt_q), .lock_d(lock_d), .err_d(err_d)
`ifdef STICKY_ERR_EN
    , .sticky_q(sticky_q), .sticky_d(sticky_d)
`endif
  );

  always_comb begin
    all_ok_d = (&lock_d) && !(|err_d);
`ifdef STICKY_ERR_EN
    all_ok_d = all_ok_d && !(|sticky_d);
`endif
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) all_ok_q <= 1'b0;
    else       all_ok_q <= all_ok_d;
  end

  assign bus.O_lock    = lock_q;
  assign bus.O_err     = err_q;
  assign bus.O_err_cnt = cnt_q;
  assign bus.O_all_ok  = all_ok_q;
`ifdef STICKY_ERR_EN
  assign bus.O_err_sticky = sticky_q;
`endif
endmodule

// File: tb/tb_rgb_link_monitor.sv
// Scenario bench for rgb_link_monitor: a 2-link 24-bit instance plus a 1-link
// instance with a 4-bit counter for saturation; expectations queued per cycle.
module tb_rgb_link_monitor;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rgb_link_monitor_if #(.LINKS(2), .DATA_W(24), .ERR_CNT_W(16)) lif();
  rgb_link_monitor_if #(.LINKS(1), .DATA_W(8),  .ERR_CNT_W(4))  sif();

  rgb_link_monitor #(.LINKS(2), .DATA_W(24), .LOCK_CNT(16), .UNLOCK_ERR(4), .ERR_CNT_W(16))
    dut (.I_clk(clk), .I_rst(rst), .bus(lif.slave));
  rgb_link_monitor #(.LINKS(1), .DATA_W(8), .LOCK_CNT(2), .UNLOCK_ERR(32), .ERR_CNT_W(4))
    dut_s (.I_clk(clk), .I_rst(rst), .bus(sif.slave));

  typedef struct packed {
    logic [1:0]  lock;
    logic [1:0]  err;
    logic [15:0] cnt0;
    logic [15:0] cnt1;
    logic        all_ok;
`ifdef STICKY_ERR_EN
    logic [1:0]  sticky;
`endif
  } exp_t;

  typedef struct packed {
    logic       lock;
    logic       err;
    logic [3:0] cnt;
  } sexp_t;

  int    checks = 0;
  int    errors = 0;
  exp_t  sb[$], got[$];
  sexp_t ssb[$], sgot[$];
  logic [1:0]  e_sticky = 2'b00;
  logic [23:0] n0, n1;
  logic [15:0] e_cnt0;

  function automatic exp_t observe();
    exp_t o;
    o.lock   = lif.O_lock;
    o.err    = lif.O_err;
    o.cnt0   = lif.O_err_cnt[0];
    o.cnt1   = lif.O_err_cnt[1];
    o.all_ok = lif.O_all_ok;
`ifdef STICKY_ERR_EN
    o.sticky = lif.O_err_sticky;
`endif
    return o;
  endfunction

  // drive one cycle on the 2-link DUT and queue what it must show afterwards
  task automatic cyc(input logic [1:0] v, input logic [23:0] d0, input logic [23:0] d1,
                     input logic clr, input logic [1:0] lk, input logic [1:0] er,
                     input logic [15:0] c0, input logic [15:0] c1);
    exp_t e;
    lif.I_valid   = v;
    lif.I_data    = {d1, d0};
    lif.I_clr_cnt = clr;
    e.lock = lk;
    e.err  = er;
    e.cnt0 = c0;
    e.cnt1 = c1;
`ifdef STICKY_ERR_EN
    e_sticky = er | (clr ? 2'b00 : e_sticky);
    e.sticky = e_sticky;
    e.all_ok = (&lk) && !(|er) && !(|e_sticky);
`else
    e.all_ok = (&lk) && !(|er);
`endif
    sb.push_back(e);
    @(posedge clk); #1;
    got.push_back(observe());
  endtask

  task automatic scyc(input logic v, input logic [7:0] d, input logic clr,
                      input logic lk, input logic er, input logic [3:0] c);
    sif.I_valid   = v;
    sif.I_data    = d;
    sif.I_clr_cnt = clr;
    ssb.push_back({lk, er, c});
    @(posedge clk); #1;
    sgot.push_back({sif.O_lock, sif.O_err, sif.O_err_cnt});
  endtask

  // reset cycle with every other input active: reset must win
  task automatic rst_cyc();
    rst           = 1'b1;
    lif.I_valid   = 2'b11;
    lif.I_clr_cnt = 1'b1;
    lif.I_data    = {24'h123456, 24'hABCDEF};
    sif.I_valid   = 1'b1;
    sif.I_data    = 8'h33;
    sif.I_clr_cnt = 1'b0;
    e_sticky      = 2'b00;
    sb.push_back('0);
    @(posedge clk); #1;
    got.push_back(observe());
    rst           = 1'b0;
    lif.I_valid   = 2'b00;
    lif.I_clr_cnt = 1'b0;
    sif.I_valid   = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e, a;
    rst_cyc();
    rst_cyc();
    cyc(2'b00, 24'h0, 24'h0, 1'b0, 2'b00, 2'b00, 16'd0, 16'd0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); a = got.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL reset got %h exp %h", a, e); end
    end
  endtask

  task automatic test_lock();
    exp_t e, a;
    for (int i = 0; i < 17; i++)
      cyc(2'b01, 24'(i), 24'h0, 1'b0, {1'b0, i == 16}, 2'b00, 16'd0, 16'd0);
    cyc(2'b00, 24'h0, 24'h0, 1'b0, 2'b01, 2'b00, 16'd0, 16'd0);
    n0 = 24'd17;
    while (sb.size() > 0) begin
      e = sb.pop_front(); a = got.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL lock_seq got %h exp %h", a, e); end
    end
  endtask

  task automatic test_wrap();
    exp_t e, a;
    logic [23:0] t1;
    for (int j = 0; j < 20; j++) begin
      t1 = 24'hFFFFEE + 24'(j);
      cyc(2'b11, n0, t1, 1'b0, {j >= 16, 1'b1}, 2'b00, 16'd0, 16'd0);
      n0 = n0 + 24'd1;
    end
    n1 = 24'd2;
    while (sb.size() > 0) begin
      e = sb.pop_front(); a = got.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL wrap got %h exp %h", a, e); end
    end
  endtask

  task automatic test_err();
    exp_t e, a;
    logic [23:0] x;
    x = n0;
    cyc(2'b01, x,          24'h0, 1'b0, 2'b11, 2'b00, 16'd0, 16'd0);
    cyc(2'b01, x + 24'd1,  24'h0, 1'b0, 2'b11, 2'b00, 16'd0, 16'd0);
    cyc(2'b01, x + 24'd41, 24'h0, 1'b0, 2'b11, 2'b01, 16'd1, 16'd0);
    cyc(2'b01, x + 24'd42, 24'h0, 1'b0, 2'b11, 2'b00, 16'd1, 16'd0);
    n0 = x + 24'd43;
    e_cnt0 = 16'd1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); a = got.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL single_err got %h exp %h", a, e); end
    end
  endtask

  // 3 bad, 1 good, 3 bad: a good sample restarts the run, so lock survives
  task automatic test_bad_run();
    exp_t e, a;
    logic [23:0] p, v;
    logic er;
    p = n0 - 24'd1;
    for (int k = 0; k < 8; k++) begin
      er = !(k == 3 || k == 7);
      v  = er ? p + 24'd3 : p + 24'd1;
      if (er) e_cnt0 = e_cnt0 + 16'd1;
      cyc(2'b01, v, 24'h0, 1'b0, 2'b11, {1'b0, er}, e_cnt0, 16'd0);
      p = v;
    end
    n0 = p + 24'd1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); a = got.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL bad_run got %h exp %h", a, e); end
    end
  endtask

  task automatic test_unlock();
    exp_t e, a;
    logic [23:0] p, r;
    cyc(2'b00, 24'h0, 24'h0, 1'b1, 2'b11, 2'b00, 16'd0, 16'd0);
    p = n0 - 24'd1;
    for (int k = 0; k < 4; k++) begin
      r = 24'($urandom());
      while (r == p + 24'd1) r = 24'($urandom());
      cyc(2'b01, r, 24'h0, 1'b0, {1'b1, k != 3}, 2'b01, 16'(k + 1), 16'd0);
      p = r;
    end
    for (int k = 0; k < 16; k++) begin
      p = p + 24'd1;
      cyc(2'b01, p, 24'h0, 1'b0, {1'b1, k == 15}, 2'b00, 16'd4, 16'd0);
    end
    n0 = p + 24'd1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); a = got.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL unlock got %h exp %h", a, e); end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e, a;
    cyc(2'b11, n0,          n1,          1'b0, 2'b11, 2'b00, 16'd4, 16'd0);
    cyc(2'b11, n0 + 24'd1,  n1 + 24'd1,  1'b0, 2'b11, 2'b00, 16'd4, 16'd0);
    rst_cyc();
    cyc(2'b11, n0 + 24'd2,  n1 + 24'd2,  1'b0, 2'b00, 2'b00, 16'd0, 16'd0);
    cyc(2'b11, n0 + 24'd3,  n1 + 24'd3,  1'b0, 2'b00, 2'b00, 16'd0, 16'd0);
    while (sb.size() > 0) begin
      e = sb.pop_front(); a = got.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL reset_mid got %h exp %h", a, e); end
    end
  endtask

  task automatic test_sat();
    sexp_t e, a;
    lif.I_valid   = 2'b00;
    lif.I_clr_cnt = 1'b0;
    scyc(1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 4'd0);
    scyc(1'b1, 8'd1, 1'b0, 1'b0, 1'b0, 4'd0);
    scyc(1'b1, 8'd2, 1'b0, 1'b1, 1'b0, 4'd0);
    for (int k = 0; k < 20; k++)
      scyc(1'b1, 8'h80, 1'b0, 1'b1, 1'b1, (k + 1 > 15) ? 4'd15 : 4'(k + 1));
    scyc(1'b1, 8'h80, 1'b1, 1'b1, 1'b1, 4'd1);
    scyc(1'b0, 8'h80, 1'b1, 1'b1, 1'b0, 4'd0);
    while (ssb.size() > 0) begin
      e = ssb.pop_front(); a = sgot.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL sat got %h exp %h", a, e); end
    end
  endtask

  initial begin
    lif.I_valid = 2'b00; lif.I_data = '0; lif.I_clr_cnt = 1'b0;
    sif.I_valid = 1'b0;  sif.I_data = '0; sif.I_clr_cnt = 1'b0;
    test_reset();
    test_lock();
    test_wrap();
    test_err();
    test_bad_run();
    test_unlock();
    test_reset_mid();
    test_sat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
